// File: rtl/mem_op_controller.sv
// mem_op_controller: runs one STORE/ADD/SUB/RSUM command at a time against a 16x8 register memory.
// Reads go through the memory's two combinational ports; the result is written back in a single WRITE cycle.
module mem_op_controller (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic [1:0] opcode,
  input  logic [3:0] addrA,
  input  logic [3:0] addrB,
  input  logic [3:0] addrD,
  input  logic [7:0] imm,
  input  logic [7:0] memReadData1,
  input  logic [7:0] memReadData2,
  output logic [3:0] memReadAddress1,
  output logic [3:0] memReadAddress2,
  output logic       memWriteEnable,
  output logic [3:0] memWriteAddress,
  output logic [7:0] memWriteData,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       flag
);
  typedef enum logic [2:0] {IDLE, EXEC, ACCUM, WRITE, DONE} state_t;
  state_t     r_state;
  logic       r_sub, r_flag, r_busy, r_done, r_we;
  logic [3:0] r_ptr, r_b, r_d;
  logic [7:0] r_result;
  logic [8:0] w_add, w_sub, w_acc;
  assign w_add = {1'b0, memReadData1} + {1'b0, memReadData2};
  assign w_sub = {1'b0, memReadData1} - {1'b0, memReadData2};
  assign w_acc = {1'b0, r_result} + {1'b0, memReadData1};
  assign memReadAddress1 = r_ptr;
  assign memReadAddress2 = r_b;
  assign memWriteEnable  = r_we;
  assign memWriteAddress = r_d;
  assign memWriteData    = r_result;
  assign busy            = r_busy;
  assign done            = r_done;
  assign result          = r_result;
  assign flag            = r_flag;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_sub    <= 1'b0;
      r_flag   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      r_ptr    <= 4'd0;
      r_b      <= 4'd0;
      r_d      <= 4'd0;
      r_result <= 8'd0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_ptr  <= addrA;
          r_b    <= addrB;
          r_d    <= addrD;
          r_sub  <= opcode[1];
          r_busy <= 1'b1;
          if (opcode == 2'b00) begin
            r_result <= imm;
            r_flag   <= 1'b0;
            r_we     <= 1'b1;
            r_state  <= WRITE;
          end else if (opcode == 2'b11) begin
            r_result <= 8'd0;
            r_flag   <= 1'b0;
            r_state  <= ACCUM;
          end else begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          {r_flag, r_result} <= r_sub ? w_sub : w_add;
          r_we    <= 1'b1;
          r_state <= WRITE;
        end
        // the range end is inclusive: the element at ptr==B is summed before leaving
        ACCUM: begin
          r_result <= w_acc[7:0];
          r_flag   <= r_flag | w_acc[8];
          r_ptr    <= r_ptr + 4'd1;
          if (r_ptr == r_b) begin
            r_we    <= 1'b1;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_op_controller.sv
// tb_mem_op_controller: bench memory plus a command-level model checked every cycle, with directed literal checks.
module tb_mem_op_controller;
  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic [1:0] opcode = 2'd0;
  logic [3:0] addrA = 4'd0, addrB = 4'd0, addrD = 4'd0;
  logic [7:0] imm = 8'd0;
  logic [7:0] memReadData1, memReadData2;
  logic [3:0] memReadAddress1, memReadAddress2, memWriteAddress;
  logic       memWriteEnable, busy, done, flag;
  logic [7:0] memWriteData, result;
  logic [7:0] mem [16];
  int n_chk = 0;
  int n_err = 0;

  mem_op_controller dut (
    .clk(clk), .resetN(resetN), .start(start), .opcode(opcode),
    .addrA(addrA), .addrB(addrB), .addrD(addrD), .imm(imm),
    .memReadData1(memReadData1), .memReadData2(memReadData2),
    .memReadAddress1(memReadAddress1), .memReadAddress2(memReadAddress2),
    .memWriteEnable(memWriteEnable), .memWriteAddress(memWriteAddress),
    .memWriteData(memWriteData), .busy(busy), .done(done),
    .result(result), .flag(flag)
  );

  always #5 clk = ~clk;

  assign memReadData1 = mem[memReadAddress1];
  assign memReadData2 = mem[memReadAddress2];
  always @(posedge clk) if (memWriteEnable) mem[memWriteAddress] <= memWriteData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] rs(input logic [3:0] a, input int n);
    int s = 0;
    logic f = 1'b0;
    for (int i = 0; i < n; i++) begin
      s += int'(mem[4'(a + 4'(i))]);
      if (s > 255) begin
        f = 1'b1;
        s -= 256;
      end
    end
    return {f, 8'(s)};
  endfunction

  function automatic int rs_len(input logic [3:0] a, input logic [3:0] b);
    return int'(4'(b - a)) + 1;
  endfunction

  function automatic logic [8:0] calc(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [7:0] im);
    int x = int'(mem[a]);
    int y = int'(mem[b]);
    if (op == 2'd0) return {1'b0, im};
    if (op == 2'd1) return 9'(x + y);
    if (op == 2'd2) return {x < y, 8'(x - y)};
    return rs(a, rs_len(a, b));
  endfunction

  function automatic int lat(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    return op == 2'd0 ? 1 : op == 2'd3 ? rs_len(a, b) + 1 : 2;
  endfunction

  // model: cycle m_t after acceptance; WRITE at m_t==m_lat, DONE at m_lat+1
  logic       m_active;
  int         m_t, m_lat;
  logic [1:0] m_op;
  logic [3:0] m_a, m_b, m_d;
  logic [8:0] m_last, m_prev;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_lat    <= 0;
      m_op     <= 2'd0;
      m_a      <= 4'd0;
      m_b      <= 4'd0;
      m_d      <= 4'd0;
      m_last   <= 9'd0;
      m_prev   <= 9'd0;
    end else if (m_active) begin
      m_t <= m_t + 1;
      if (m_t == m_lat + 1) m_active <= 1'b0;
    end else if (start) begin
      m_active <= 1'b1;
      m_t      <= 1;
      m_op     <= opcode;
      m_a      <= addrA;
      m_b      <= addrB;
      m_d      <= addrD;
      m_lat    <= lat(opcode, addrA, addrB);
      m_prev   <= m_last;
      m_last   <= calc(opcode, addrA, addrB, imm);
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (resetN === 1'b1) begin
      e = (!m_active || m_t >= m_lat) ? m_last : (m_op == 2'd3 ? rs(m_a, m_t - 1) : m_prev);
      chk("busy", busy, m_active);
      chk("done", done, m_active && m_t == m_lat + 1);
      chk("we", memWriteEnable, m_active && m_t == m_lat);
      chk("result", result, e[7:0]);
      chk("flag", flag, e[8]);
      if (m_active && m_t == m_lat) begin
        chk("waddr", memWriteAddress, m_d);
        chk("wdata", memWriteData, m_last[7:0]);
      end
      if (m_active && m_t < m_lat && m_op != 2'd0) begin
        chk("raddr1", memReadAddress1, m_op == 2'd3 ? 4'(m_a + 4'(m_t - 1)) : m_a);
        chk("raddr2", memReadAddress2, m_b);
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_we"}, memWriteEnable, 0);
    chk({tag, "_waddr"}, memWriteAddress, 0);
    chk({tag, "_wdata"}, memWriteData, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_flag"}, flag, 0);
    chk({tag, "_ra1"}, memReadAddress1, 0);
    chk({tag, "_ra2"}, memReadAddress2, 0);
  endtask

  task automatic run(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                     input logic [7:0] im, input int exp_done, input bit noise);
    int got = 0;
    @(negedge clk);
    opcode = op; addrA = a; addrB = b; addrD = d; imm = im; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40 && got == 0; c++) begin
      @(negedge clk);
      start = noise && c < 10;
      if (noise) begin
        opcode = 2'($urandom); addrA = 4'($urandom); addrB = 4'($urandom);
        addrD = 4'($urandom); imm = 8'($urandom);
      end
      if (done) got = c;
    end
    start = 1'b0;
    chk("done_cycle", got, exp_done);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    resetN = 1'b1;
    run(2'd0, 4'd0, 4'd0, 4'd3, 8'h5A, 2, 0);
    chk("mem3", mem[3], 8'h5A);
    chk("store_flag", flag, 0);
    run(2'd0, 4'd0, 4'd0, 4'd1, 8'hF0, 2, 0);
    run(2'd0, 4'd0, 4'd0, 4'd2, 8'h20, 2, 0);
    run(2'd1, 4'd1, 4'd2, 4'd4, 8'h00, 3, 0);
    chk("mem4", mem[4], 8'h10);
    chk("add_result", result, 8'h10);
    chk("add_flag", flag, 1);
    run(2'd2, 4'd2, 4'd1, 4'd2, 8'h00, 3, 0);
    chk("mem2_sub", mem[2], 8'h30);
    chk("sub_borrow", flag, 1);
    run(2'd0, 4'd0, 4'd0, 4'd2, 8'h20, 2, 0);
    run(2'd2, 4'd1, 4'd2, 4'd6, 8'h00, 3, 0);
    chk("mem6_sub", mem[6], 8'hD0);
    chk("sub_noborrow", flag, 0);
    run(2'd0, 4'd0, 4'd0, 4'd14, 8'h01, 2, 0);
    run(2'd0, 4'd0, 4'd0, 4'd15, 8'h02, 2, 0);
    run(2'd0, 4'd0, 4'd0, 4'd0, 8'h03, 2, 0);
    run(2'd3, 4'd14, 4'd0, 4'd5, 8'h00, 5, 0);
    chk("mem5_rsum", mem[5], 8'h06);
    chk("rsum_wrap_flag", flag, 0);
    run(2'd0, 4'd0, 4'd0, 4'd7, 8'h77, 2, 0);
    run(2'd3, 4'd7, 4'd7, 4'd8, 8'h00, 3, 0);
    chk("mem8_rsum1", mem[8], 8'h77);
    for (int i = 0; i < 16; i++) run(2'd0, 4'd0, 4'd0, 4'(i), 8'h20, 2, 0);
    run(2'd3, 4'd0, 4'd15, 4'd9, 8'h00, 18, 1);
    chk("mem9_rsum16", mem[9], 8'h00);
    chk("rsum16_flag", flag, 1);
    chk("mem10_ignored", mem[10], 8'h20);
    // abort an ADD during EXEC
    @(negedge clk);
    opcode = 2'd1; addrA = 4'd1; addrB = 4'd2; addrD = 4'd10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("exec_busy", busy, 1);
    #2 resetN = 1'b0;
    #1 chk_reset_outs("rst_exec");
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    chk("mem10_after_exec_rst", mem[10], 8'h20);
    // abort an ADD during WRITE
    @(negedge clk);
    opcode = 2'd1; addrA = 4'd1; addrB = 4'd2; addrD = 4'd10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("write_we", memWriteEnable, 1);
    #2 resetN = 1'b0;
    #1 chk_reset_outs("rst_write");
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    chk("mem10_after_write_rst", mem[10], 8'h20);
    run(2'd1, 4'd1, 4'd2, 4'd11, 8'h00, 3, 0);
    chk("mem11_add", mem[11], 8'h40);
    chk("add_noc_flag", flag, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
